uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Serial UART engine at the far end of the memory-mapped peripheral's UART registers.
- Serializes the byte presented on TX_DATA when TX_EN is asserted, and reports idle on TX_STATUS.
- Deserializes the UART_RX line into RX_DATA, flags a valid byte on RX_EFF, and clears the flag on an RX_READ pulse.
- Frame format is 8N1, LSB first, with 16x oversampling from a shared baud tick.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- TICK_DIV, CLK_HZ/(BAUD*16), clocks per oversample tick. Integer-truncated. Must be >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-high.
- TX_DATA  in  8  byte to send; sampled only at the start-accept cycle.
- TX_EN  in  1  level request from the peripheral register; transmission is armed by a rising edge.
- TX_STATUS  out  1  1 = transmitter idle and ready to accept.
- RX_DATA  out  8  last received byte.
- RX_EFF  out  1  1 = RX_DATA holds an unread byte.
- RX_READ  in  1  consume pulse, one or more cycles high.
- RX_OVERRUN  out  1  sticky: a byte was dropped because RX_EFF was still 1.
- RX_FRAME_ERR  out  1  one-cycle pulse when a stop bit is sampled 0.
- UART_TX  out  1  serial output; idles high.
- UART_RX  in  1  serial input; asynchronous.

Behaviour:
- Reset (sync, active-high), values on the cycle after reset is sampled high:
  - UART_TX=1, TX_STATUS=1, RX_DATA=0, RX_EFF=0, RX_OVERRUN=0, RX_FRAME_ERR=0.
  - Both FSMs go to IDLE; tick counter=0; synchronizer flops=1.
  - Reset mid-frame aborts immediately; UART_TX returns to 1 next cycle.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one clk when the counter wraps.
  - Bit period = 16 ticks.
- TX FSM (IDLE, START, DATA, STOP):
  - Internal tx_armed is set while TX_EN=0 and cleared on accept.
  - Accept when TX_EN=1, tx_armed=1 and state IDLE: latch TX_DATA, set TX_STATUS=0 next cycle, enter START, drive UART_TX=0.
  - Bit timer restarts at accept, so START lasts exactly 16 ticks.
  - DATA shifts out bits 0..7, 16 ticks each, tracked by a 3-bit index.
  - STOP drives 1 for 16 ticks, then goes to IDLE with TX_STATUS=1.
  - TX_EN held high continuously does not retransmit; TX_EN must drop and rise again.
  - TX_DATA changes during a frame are ignored.
- RX path:
  - UART_RX passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge (sync 1->0) enters START with the tick count cleared.
  - START: after 8 ticks (mid-bit), line=0 enters DATA; line=1 is a glitch and returns to IDLE with no flags.
  - DATA: sample every 16 ticks; 8 samples, LSB first, into a shift register.
  - STOP: sample after 16 ticks, then return to IDLE.
  - STOP sample=1: deliver the byte.
  - STOP sample=0: discard the byte, pulse RX_FRAME_ERR, RX_EFF unchanged.
- Byte delivery:
  - If RX_EFF=0, or RX_READ=1 in the same cycle: RX_DATA<=byte, RX_EFF<=1.
  - If RX_EFF=1 and RX_READ=0: drop the byte, keep RX_DATA, set RX_OVERRUN=1.
- RX_READ with no delivery in that cycle: RX_EFF<=0 and RX_OVERRUN<=0. RX_DATA is held. RX_READ while RX_EFF=0 has no effect.
- TX and RX are fully independent; loopback (UART_TX wired to UART_RX) must work.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - Even-parity bit inserted between bit 7 and the stop bit on TX (16 ticks); both FSMs gain a PARITY state.
  - RX compares the received parity bit with the XOR of the data bits.
  - A parity mismatch discards the byte and pulses RX_FRAME_ERR, the same as a bad stop bit.
  - Frame = 11 bit periods.
- Undefined: 8N1 only, no PARITY state, frame = 10 bit periods.

Test Plan (CLK_HZ=1600000, BAUD=10000 -> TICK_DIV=10, 160 clk/bit):
- TX_DATA=0xA5, TX_EN 0->1 -> TX_STATUS=0 next cycle. UART_TX sequence is 0,1,0,1,0,0,1,0,1,1, each level 160 clk. TX_STATUS=1 after 1600 clk (1760 clk with UART_PARITY_EN; parity bit 0).
- TX_EN held 1 for 5000 clk after 0x3C -> exactly one frame sent. Drop TX_EN for 1 clk, raise it again -> second frame starts.
- Loopback, send 0x5A -> RX_EFF=1 with RX_DATA=0x5A within 1600+4 clk of the start edge. RX_READ pulse -> RX_EFF=0 next cycle.
- Two frames 0x11 then 0x22 with no RX_READ -> RX_DATA=0x11, RX_EFF=1, RX_OVERRUN=1. RX_READ clears both.
- Drive UART_RX low for 40 clk, then high -> glitch rejected: no RX_EFF, no RX_FRAME_ERR. Frame 0x81 with stop bit forced 0 -> one-cycle RX_FRAME_ERR, RX_EFF stays 0.
- Assert reset mid-TX (bit 3) and mid-RX -> next cycle UART_TX=1, TX_STATUS=1, RX_EFF=0. A fresh 0x7E transfers correctly afterward.

Source files
------------

// File: rtl/uart_core.sv
// 8N1 UART engine with 16x oversampling from a shared baud tick.
// Define UART_PARITY_EN to insert an even-parity bit (8E1) on TX and check it on RX.
module uart_core #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned TICK_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic [7:0] RX_DATA,
  output logic       RX_EFF,
  input  logic       RX_READ,
  output logic       RX_OVERRUN,
  output logic       RX_FRAME_ERR,
  output logic       UART_TX,
  input  logic       UART_RX
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [CW-1:0] div_q, div_d;
  logic          tick;

  always_comb begin
    tick  = (div_q == CW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  state_e     tx_state_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_idx_q;
  logic [7:0] tx_data_q;
  logic       tx_armed_q, tx_line_q, tx_idle_q;
  logic       tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == 4'd15);
  assign UART_TX    = tx_line_q;
  assign TX_STATUS  = tx_idle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_armed_q <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_idle_q  <= 1'b1;
    end else begin
      if (!TX_EN) tx_armed_q <= 1'b1;
      if (tick)   tx_tick_q  <= tx_tick_q + 4'd1;
      // Accept overrides the tick increment so START spans exactly 16 ticks.
      case (tx_state_q)
        S_IDLE: if (TX_EN && tx_armed_q) begin
          tx_armed_q <= 1'b0;
          tx_data_q  <= TX_DATA;
          tx_tick_q  <= '0;
          tx_line_q  <= 1'b0;
          tx_idle_q  <= 1'b0;
          tx_state_q <= S_START;
        end
        S_START: if (tx_bit_end) begin
          tx_line_q  <= tx_data_q[0];
          tx_idx_q   <= '0;
          tx_state_q <= S_DATA;
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_line_q  <= ^tx_data_q;
            tx_state_q <= S_PARITY;
`else
            tx_line_q  <= 1'b1;
            tx_state_q <= S_STOP;
`endif
          end else begin
            tx_idx_q  <= tx_idx_q + 3'd1;
            tx_line_q <= tx_data_q[tx_idx_q + 3'd1];
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (tx_bit_end) begin
          tx_line_q  <= 1'b1;
          tx_state_q <= S_STOP;
        end
`endif
        S_STOP: if (tx_bit_end) begin
          tx_idle_q  <= 1'b1;
          tx_state_q <= S_IDLE;
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  state_e     rx_state_q;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_idx_q;
  logic [7:0] rx_shift_q, rx_data_q;
  logic       rx_eff_q, rx_ovr_q, rx_ferr_q;
  logic       rx_mid, rx_bit_end, rx_stop_now, rx_good;
`ifdef UART_PARITY_EN
  logic       rx_perr_q;
`endif

  assign rx_mid      = tick && (rx_tick_q == 4'd7);
  assign rx_bit_end  = tick && (rx_tick_q == 4'd15);
  assign rx_stop_now = (rx_state_q == S_STOP) && rx_bit_end;
`ifdef UART_PARITY_EN
  assign rx_good     = rx_stop_now && rx_s2_q && !rx_perr_q;
`else
  assign rx_good     = rx_stop_now && rx_s2_q;
`endif

  assign RX_DATA      = rx_data_q;
  assign RX_EFF       = rx_eff_q;
  assign RX_OVERRUN   = rx_ovr_q;
  assign RX_FRAME_ERR = rx_ferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_tick_q  <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_eff_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= UART_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_ferr_q <= 1'b0;
      if (tick) rx_tick_q <= rx_tick_q + 4'd1;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_tick_q  <= '0;
          rx_state_q <= S_START;
        end
        S_START: if (rx_mid) begin
          rx_tick_q  <= '0;
          rx_idx_q   <= '0;
`ifdef UART_PARITY_EN
          rx_perr_q  <= 1'b0;
`endif
          rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_idx_q   <= rx_idx_q + 3'd1;
`ifdef UART_PARITY_EN
          if (rx_idx_q == 3'd7) rx_state_q <= S_PARITY;
`else
          if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
`endif
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (rx_bit_end) begin
          rx_perr_q  <= rx_s2_q ^ (^rx_shift_q);
          rx_state_q <= S_STOP;
        end
`endif
        S_STOP: if (rx_bit_end) begin
          rx_ferr_q  <= !rx_good;
          rx_state_q <= S_IDLE;
        end
        default: rx_state_q <= S_IDLE;
      endcase
      if (rx_good) begin
        if (!rx_eff_q || RX_READ) begin
          rx_data_q <= rx_shift_q;
          rx_eff_q  <= 1'b1;
        end else begin
          rx_ovr_q  <= 1'b1;
        end
      end else if (RX_READ) begin
        rx_eff_q <= 1'b0;
        rx_ovr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at TICK_DIV=10 (160 clk per bit), TX checked at bit midpoints.
module tb_uart_core;

`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       TX_STATUS;
  logic [7:0] RX_DATA;
  logic       RX_EFF;
  logic       RX_READ;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;
  logic       UART_TX;
  logic       rx_drv, loop;
  logic       rx_line;

  int n_cmp = 0;
  int n_bad = 0;

  assign rx_line = loop ? UART_TX : rx_drv;

  uart_core #(.CLK_HZ(1600000), .BAUD(10000)) dut (
    .clk(clk), .reset(reset), .TX_DATA(TX_DATA), .TX_EN(TX_EN),
    .TX_STATUS(TX_STATUS), .RX_DATA(RX_DATA), .RX_EFF(RX_EFF),
    .RX_READ(RX_READ), .RX_OVERRUN(RX_OVERRUN), .RX_FRAME_ERR(RX_FRAME_ERR),
    .UART_TX(UART_TX), .UART_RX(rx_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Drop TX_EN for one clock, raise it with new data; returns at the negedge after accept.
  task automatic tx_start(input logic [7:0] d);
    TX_EN = 1'b0;
    @(negedge clk);
    TX_DATA = d;
    TX_EN   = 1'b1;
    @(negedge clk);
  endtask

  task automatic tx_frame(input logic [7:0] d);
    int m;
    tx_start(d);
    check("tx_busy_on_accept", TX_STATUS, 1'b0);
    TX_DATA = ~d;
    m = 0;
    for (int i = 0; i < FB; i++) begin
      repeat (75 + 160*i - m) @(negedge clk);
      m = 75 + 160*i;
      check($sformatf("tx_bit%0d_%02h", i, d), UART_TX, frame_bit(d, i));
    end
    repeat (160*FB - 10 - m) @(negedge clk);
    check("tx_busy_before_end", TX_STATUS, 1'b0);
    repeat (10) @(negedge clk);
    check("tx_idle_after_frame", TX_STATUS, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 2000 && !TX_STATUS; n++) @(negedge clk);
    check(tag, TX_STATUS, 1'b1);
  endtask

  task automatic read_pulse;
    RX_READ = 1'b1;
    @(negedge clk);
    RX_READ = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop, output int ferr_n);
    ferr_n = 0;
    for (int i = 0; i < FB; i++) begin
      rx_drv = (i == FB - 1) ? stop : frame_bit(d, i);
      repeat (160) begin
        @(negedge clk);
        if (RX_FRAME_ERR) ferr_n++;
      end
    end
    rx_drv = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (RX_FRAME_ERR) ferr_n++;
    end
  endtask

  initial begin
    int cnt;
    int seen;
    reset = 1'b1; TX_EN = 1'b0; TX_DATA = '0; RX_READ = 1'b0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", UART_TX, 1'b1);
    check("rst_tx_status", TX_STATUS, 1'b1);
    check("rst_rx_data", RX_DATA, 8'h00);
    check("rst_rx_eff", RX_EFF, 1'b0);
    check("rst_rx_ovr", RX_OVERRUN, 1'b0);
    check("rst_rx_ferr", RX_FRAME_ERR, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    tx_frame(8'hA5);

    // TX_EN stays high: exactly one frame, then a drop/raise restarts.
    tx_frame(8'h3C);
    cnt = 0;
    repeat (5000) begin
      @(negedge clk);
      if (!UART_TX || !TX_STATUS) cnt++;
    end
    check("tx_no_retransmit", cnt, 0);
    tx_frame(8'hC3);

    loop = 1'b1;
    tx_start(8'h5A);
    seen = 0;
    for (int n = 0; n < 160*FB + 4 && !RX_EFF; n++) @(negedge clk);
    check("lb_rx_eff", RX_EFF, 1'b1);
    check("lb_rx_data", RX_DATA, 8'h5A);
    wait_idle("lb_tx_idle");
    read_pulse();
    check("lb_read_clears_eff", RX_EFF, 1'b0);
    check("lb_read_holds_data", RX_DATA, 8'h5A);

    tx_start(8'h11);
    wait_idle("ovr_tx1_idle");
    tx_start(8'h22);
    wait_idle("ovr_tx2_idle");
    repeat (20) @(negedge clk);
    check("ovr_rx_data", RX_DATA, 8'h11);
    check("ovr_rx_eff", RX_EFF, 1'b1);
    check("ovr_flag", RX_OVERRUN, 1'b1);
    read_pulse();
    check("ovr_read_eff", RX_EFF, 1'b0);
    check("ovr_read_flag", RX_OVERRUN, 1'b0);

    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (RX_FRAME_ERR || RX_EFF) seen++;
    end
    check("glitch_no_flags", seen, 0);
    rx_send(8'h81, 1'b0, cnt);
    check("ferr_one_pulse", cnt, 1);
    check("ferr_no_eff", RX_EFF, 1'b0);
    rx_send(8'h81, 1'b1, cnt);
    check("good_no_ferr", cnt, 0);
    check("good_rx_eff", RX_EFF, 1'b1);
    check("good_rx_data", RX_DATA, 8'h81);

    // Leave RX_EFF set, then reset during data bit 3 of a loopback frame.
    loop = 1'b1;
    tx_start(8'hF0);
    repeat (75 + 160*4) @(negedge clk);
    check("pre_rst_tx_busy", TX_STATUS, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_uart_tx", UART_TX, 1'b1);
    check("mid_rst_tx_status", TX_STATUS, 1'b1);
    check("mid_rst_rx_eff", RX_EFF, 1'b0);
    check("mid_rst_rx_data", RX_DATA, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tx_frame(8'h7E);
    check("post_rst_rx_eff", RX_EFF, 1'b1);
    check("post_rst_rx_data", RX_DATA, 8'h7E);
    check("post_rst_no_ovr", RX_OVERRUN, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
